// File: rtl/pgm_pkg.sv
// Shared definitions for the packet-generator write side: word tags, template
// field positions, register map and the classifier state encoding.
package pgm_pkg;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [2:0] TEMPLATE_MARK = 3'b111;
  localparam int         TMPL_MARK_LSB = 109;
  localparam int         TMPL_SEL_LSB  = 106;

  localparam logic [3:0] REG_TLIM_LO  = 4'd0;
  localparam logic [3:0] REG_TLIM_HI  = 4'd1;
  localparam logic [3:0] REG_RUN      = 4'd2;
  localparam logic [3:0] REG_TCNT_LO  = 4'd3;
  localparam logic [3:0] REG_TCNT_HI  = 4'd4;
  localparam logic [3:0] REG_STATUS   = 4'd5;
  localparam logic [3:0] REG_SLOT_CLR = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYPASS = 2'd1,
    ST_STORE  = 2'd2,
    ST_DROP   = 2'd3
  } state_e;

endpackage

// File: rtl/pgm_wr_mslot_if.sv
// Packet word stream from the upstream stage, with almost-full back-pressure.
interface pgm_wr_mslot_if #(
  parameter int DATA_W = 134
);
  logic [DATA_W-1:0] data;
  logic              data_wr;
  logic              alf;

  modport master (output data, output data_wr, input alf);
  modport slave  (input data, input data_wr, output alf);
endinterface

// File: rtl/pgm_run_timer.sv
// Generation-run timer: owns run_en and the 64-bit time limit, and frames a
// run with gen_start / gen_active / gen_finish while counting cycles.
module pgm_run_timer
  import pgm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  input  logic        slot_any_i,
  output logic        run_en_o,
  output logic        gen_active_o,
  output logic        gen_start_o,
  output logic        gen_finish_o,
  output logic [63:0] time_cnt_o,
  output logic [63:0] time_limit_o
);

  logic [63:0] tlim_q, tlim_d, cnt_q, cnt_d;
  logic        run_q, run_d, act_q, act_d, start_q, start_d, fin_q, fin_d;

  always_comb begin
    tlim_d  = tlim_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    act_d   = act_q;
    start_d = 1'b0;
    fin_d   = 1'b0;
    if (!act_q) begin
      if (run_q && slot_any_i) begin
        act_d   = 1'b1;
        start_d = 1'b1;
        cnt_d   = '0;
      end
    end else if (!run_q || tlim_q == 64'd0 || cnt_q >= tlim_q - 64'd1) begin
      // run_en self-clears so a finished run never restarts on its own
      act_d = 1'b0;
      fin_d = 1'b1;
      run_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 64'd1;
    end
    if (cfg_wr_i) begin
      case (cfg_addr_i)
        REG_TLIM_LO: tlim_d[31:0]  = cfg_wdata_i;
        REG_TLIM_HI: tlim_d[63:32] = cfg_wdata_i;
        REG_RUN:     run_d         = cfg_wdata_i[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlim_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      act_q   <= 1'b0;
      start_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      tlim_q  <= tlim_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      act_q   <= act_d;
      start_q <= start_d;
      fin_q   <= fin_d;
    end
  end

  assign run_en_o     = run_q;
  assign gen_active_o = act_q;
  assign gen_start_o  = start_q;
  assign gen_finish_o = fin_q;
  assign time_cnt_o   = cnt_q;
  assign time_limit_o = tlim_q;

endmodule

// File: rtl/pgm_wr_mslot.sv
// Packet-generator write side: stores template packets into RAM slots,
// bypasses everything else with a per-packet verdict, and hosts the run timer.
module pgm_wr_mslot
  import pgm_pkg::*;
#(
  parameter int DATA_W     = 134,
  parameter int SLOTS      = 4,
  parameter int SLOT_DEPTH = 32,
  parameter int SLOT_AW    = $clog2(SLOT_DEPTH),
  parameter int SEL_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  parameter int RAM_W      = 144
) (
  input  logic                         clk,
  input  logic                         rst,
  pgm_wr_mslot_if.slave                in_s,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_data_wr,
  output logic                         out_valid,
  output logic                         out_valid_wr,
  input  logic                         in_alf,
  output logic                         ram_wr_en,
  output logic [SEL_W+SLOT_AW-1:0]     ram_addr,
  output logic [RAM_W-1:0]             ram_wdata,
  output logic [SLOTS-1:0]             slot_valid,
  output logic [SLOTS*(SLOT_AW+1)-1:0] slot_len,
  output logic                         gen_active,
  output logic                         gen_start,
  output logic                         gen_finish,
  input  logic                         cfg_wr,
  input  logic [3:0]                   cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  output logic [31:0]                  cfg_rdata,
  output logic [15:0]                  err_cnt
);

  localparam int               AW   = SEL_W + SLOT_AW;
  localparam int               LW   = SLOT_AW + 1;
  localparam logic [SLOT_AW:0] FULL = LW'(SLOT_DEPTH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     slot_q, slot_d, sel;
  logic [SLOT_AW:0]     cnt_q, cnt_d;
  logic [SLOTS-1:0]     sv_q, sv_d, clr_mask;
  logic [SLOTS*LW-1:0]  len_q;
  logic [DATA_W-1:0]    word, out_data_q;
  logic [AW-1:0]        addr_d, ram_addr_q;
  logic [RAM_W-1:0]     ram_wdata_q;
  logic [15:0]          err_q;
  logic [31:0]          rdata_d, rdata_q;
  logic [63:0]          time_cnt, time_limit;
  logic wr, is_head, is_tail, is_tmpl, classify, fwd, ram_we, err_inc;
  logic pend_set, abort_vld, len_upd, pend_q, run_en;
  logic out_data_wr_q, out_valid_q, out_valid_wr_q, ram_wr_en_q;

  assign in_s.alf = in_alf;
  assign word     = in_s.data;
  assign wr       = in_s.data_wr;
  assign is_head  = (word[DATA_W-1 -: 2] == TAG_HEAD);
  assign is_tail  = (word[DATA_W-1 -: 2] == TAG_TAIL);
  assign is_tmpl  = (word[TMPL_MARK_LSB +: 3] == TEMPLATE_MARK);
  assign clr_mask = (cfg_wr && cfg_addr == REG_SLOT_CLR) ? cfg_wdata[SLOTS-1:0] : '0;

  if (SLOTS == 1) begin : g_sel1
    assign sel = '0;
  end else begin : g_seln
    assign sel = word[TMPL_SEL_LSB +: SEL_W];
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    sv_d      = sv_q;
    classify  = 1'b0;
    fwd       = 1'b0;
    ram_we    = 1'b0;
    addr_d    = {slot_q, cnt_q[SLOT_AW-1:0]};
    err_inc   = 1'b0;
    pend_set  = 1'b0;
    abort_vld = 1'b0;
    len_upd   = 1'b0;
    if (wr) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_head) classify = 1'b1;
          else begin
            err_inc = 1'b1;
            if (!is_tail) state_d = ST_DROP;
          end
        end
        ST_BYPASS: begin
          if (is_head) begin
            err_inc   = 1'b1;
            abort_vld = 1'b1;
            classify  = 1'b1;
          end else begin
            fwd = 1'b1;
            if (is_tail) begin
              pend_set = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_STORE: begin
          if (is_head) begin
            err_inc  = 1'b1;
            classify = 1'b1;
          end else if (cnt_q == FULL) begin
            // slot already full: the packet cannot fit, discard the rest
            err_inc = 1'b1;
            state_d = is_tail ? ST_IDLE : ST_DROP;
          end else begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (is_tail) begin
              len_upd      = 1'b1;
              sv_d[slot_q] = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
        ST_DROP: if (is_tail) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    if (classify) begin
      if (is_tmpl) begin
        state_d   = ST_STORE;
        slot_d    = sel;
        cnt_d     = LW'(1);
        sv_d[sel] = 1'b0;
        ram_we    = 1'b1;
        addr_d    = {sel, {SLOT_AW{1'b0}}};
      end else begin
        state_d = ST_BYPASS;
        fwd     = 1'b1;
      end
    end
    // clearing the slot being filled aborts the store silently
    if (state_q == ST_STORE && state_d == ST_STORE && !classify && clr_mask[slot_q]) begin
      state_d = ST_DROP;
      ram_we  = 1'b0;
    end
    sv_d = sv_d & ~clr_mask;
  end

  always_comb begin
    rdata_d = 32'hFFFF_FFFF;
    case (cfg_addr)
      REG_TLIM_LO:  rdata_d = time_limit[31:0];
      REG_TLIM_HI:  rdata_d = time_limit[63:32];
      REG_RUN:      rdata_d = {31'd0, run_en};
      REG_TCNT_LO:  rdata_d = time_cnt[31:0];
      REG_TCNT_HI:  rdata_d = time_cnt[63:32];
      REG_STATUS:   rdata_d = 32'({err_q, sv_q});
      REG_SLOT_CLR: rdata_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      cnt_q          <= '0;
      sv_q           <= '0;
      len_q          <= '0;
      pend_q         <= 1'b0;
      err_q          <= '0;
      out_data_q     <= '0;
      out_data_wr_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
      ram_wr_en_q    <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      cnt_q          <= cnt_d;
      sv_q           <= sv_d;
      pend_q         <= pend_set;
      out_data_wr_q  <= fwd;
      out_valid_wr_q <= pend_q | abort_vld;
      out_valid_q    <= pend_q;
      ram_wr_en_q    <= ram_we;
      rdata_q        <= rdata_d;
      if (fwd) out_data_q <= word;
      if (ram_we) begin
        ram_addr_q  <= addr_d;
        ram_wdata_q <= RAM_W'(word);
      end
      if (len_upd) len_q[slot_q*LW +: LW] <= cnt_q + 1'b1;
      if (err_inc) err_q <= sat_inc(err_q);
    end
  end

  pgm_run_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_i     (cfg_wr),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .slot_any_i   (|sv_q),
    .run_en_o     (run_en),
    .gen_active_o (gen_active),
    .gen_start_o  (gen_start),
    .gen_finish_o (gen_finish),
    .time_cnt_o   (time_cnt),
    .time_limit_o (time_limit)
  );

  assign out_data     = out_data_q;
  assign out_data_wr  = out_data_wr_q;
  assign out_valid    = out_valid_q;
  assign out_valid_wr = out_valid_wr_q;
  assign ram_wr_en    = ram_wr_en_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign slot_valid   = sv_q;
  assign slot_len     = len_q;
  assign err_cnt      = err_q;
  assign cfg_rdata    = rdata_q;

endmodule
